simd_instr_sequencer: RTL and testbench



---
 rtl/simd_pkg.sv | 31 +++
 rtl/simd_prog_buffer.sv | 28 ++
 rtl/simd_instr_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_simd_instr_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD instruction sequencer: instruction width,
// opcodes, register-field positions and the sequencer state encoding.
package simd_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_W   = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Least-significant bit of each 3-bit register field
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Extract a register index field starting at bit lsb
  function automatic reg_idx_t field(input logic [INSTR_W-1:0] w,
                                     input int unsigned lsb);
    return w[lsb +: REG_W];
  endfunction

endpackage

// File: rtl/simd_prog_buffer.sv
// Program buffer: DEPTH x INSTR_W words, synchronous write, combinational read.
// Contents are intentionally not reset.
module simd_prog_buffer
  import simd_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Host write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simd_instr_sequencer.sv
// Program sequencer for the SIMD core: issues buffered instructions in order,
// inserts NOP bubbles on read-after-write hazards, honours issue_ready
// back-pressure and pulses done once the final result has retired.
module simd_instr_sequencer
  import simd_pkg::*;
#(
  parameter int unsigned        DEPTH      = 16,
  parameter int unsigned        HAZARD_GAP = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = {OP_NOP, 14'd0}
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [INSTR_W-1:0]       load_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic                     issue_ready,
  output logic [INSTR_W-1:0]       instruction,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  // Wide enough to hold 0..HAZARD_GAP, and at least one bit when HAZARD_GAP==0
  localparam int unsigned GW = $clog2(HAZARD_GAP + 2);

  localparam logic [LW-1:0] LEN_MAX  = LW'(DEPTH);
  localparam logic [GW-1:0] GAP_INIT = GW'(HAZARD_GAP);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] word;
  logic               wr_en;

  logic [LW-1:0]      len, len_nxt;
  logic [LW-1:0]      issued, issued_nxt;
  logic [LW-1:0]      len_req;
  logic [GW-1:0]      gap_cnt, gap_nxt;
  logic [GW-1:0]      drain_cnt, drain_nxt;
  reg_idx_t           last_rd, last_rd_nxt;

  logic [INSTR_W-1:0] instr_nxt;
  logic               valid_nxt;
  logic [AW-1:0]      pc_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  logic               hazard;
  logic               issue;
  logic               last_issue;
  logic               drain_end;

  // Loads are only honoured in IDLE so a running program cannot be corrupted
  assign wr_en = load_en && (state == IDLE);

  simd_prog_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc),
    .rd_data (word)
  );

  // Hazard detection, issue qualification and length clamping
  always_comb begin
    len_req    = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    hazard     = (gap_cnt != '0) &&
                 ((field(word, RS1_LSB) == last_rd) ||
                  (field(word, RS2_LSB) == last_rd));
    issue      = (state == RUN) && !hazard && issue_ready;
    last_issue = issue && ((issued + LW'(1)) == len);
    drain_end  = (state == DRAIN) && (drain_cnt == GAP_INIT);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && (len_req != '0)) state_nxt = RUN;
      RUN:     if (last_issue)               state_nxt = DRAIN;
      DRAIN:   if (drain_end)                state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Output and datapath next values; everything is registered below
  always_comb begin
    instr_nxt   = instruction;
    valid_nxt   = instr_valid;
    pc_nxt      = pc;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    len_nxt     = len;
    issued_nxt  = issued;
    gap_nxt     = gap_cnt;
    drain_nxt   = drain_cnt;
    last_rd_nxt = last_rd;

    unique case (state)
      IDLE: begin
        instr_nxt = NOP_INSTR;
        valid_nxt = 1'b0;
        if (start) begin
          len_nxt    = len_req;
          pc_nxt     = '0;
          issued_nxt = '0;
          gap_nxt    = '0;
          drain_nxt  = '0;
          if (len_req == '0) begin
            done_nxt = 1'b1;
          end else begin
            busy_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        // The gap counter runs down even while the core stalls us, so a
        // stall overlapping a hazard window costs no extra bubble.
        if (gap_cnt != '0) gap_nxt = gap_cnt - GW'(1);
        if (hazard) begin
          instr_nxt = NOP_INSTR;
          valid_nxt = 1'b0;
        end else if (issue_ready) begin
          instr_nxt   = word;
          valid_nxt   = 1'b1;
          pc_nxt      = pc + AW'(1);
          issued_nxt  = issued + LW'(1);
          last_rd_nxt = field(word, RD_LSB);
          gap_nxt     = GAP_INIT;
          if (last_issue) drain_nxt = '0;
        end
      end

      DRAIN: begin
        instr_nxt = NOP_INSTR;
        valid_nxt = 1'b0;
        if (gap_cnt != '0) gap_nxt = gap_cnt - GW'(1);
        if (drain_end) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          pc_nxt   = '0;
        end else begin
          drain_nxt = drain_cnt + GW'(1);
        end
      end

      default: begin
        instr_nxt = NOP_INSTR;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Registered outputs and sequencing counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len         <= '0;
      issued      <= '0;
      gap_cnt     <= '0;
      drain_cnt   <= '0;
      last_rd     <= '0;
    end else begin
      instruction <= instr_nxt;
      instr_valid <= valid_nxt;
      pc          <= pc_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      len         <= len_nxt;
      issued      <= issued_nxt;
      gap_cnt     <= gap_nxt;
      drain_cnt   <= drain_nxt;
      last_rd     <= last_rd_nxt;
    end
  end

endmodule

// File: tb/tb_simd_instr_sequencer.sv
// Directed testbench for simd_instr_sequencer: a table of cycle-by-cycle
// vectors plus hand-written multi-cycle sequences.
module tb_simd_instr_sequencer;
  import simd_pkg::*;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned HAZARD_GAP = 1;
  localparam logic [15:0] NOP        = 16'hC000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [15:0] load_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        issue_ready;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  simd_instr_sequencer #(
    .DEPTH      (DEPTH),
    .HAZARD_GAP (HAZARD_GAP),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .issue_ready (issue_ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic        le;
    logic [3:0]  la;
    logic [15:0] ld;
    logic        st;
    logic [4:0]  len;
    logic        rdy;
    logic [15:0] e_instr;
    logic        e_valid;
    logic [3:0]  e_pc;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] mk(input logic [1:0] op, input int rd,
                                     input int rs1, input int rs2, input int lo);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 5'(lo)};
  endfunction

  // Full-depth program word: rd=r0, sources r1/r2, index in low bits
  function automatic logic [15:0] fw(input int i);
    return mk((i % 2 == 1) ? OP_MUL : OP_ADD, 0, 1, 2, i);
  endfunction

  function automatic vec_t row(input logic le, input int la, input logic [15:0] ld,
                               input logic st, input int len, input logic rdy,
                               input logic [15:0] ei, input logic ev, input int ep,
                               input logic eb, input logic ed);
    vec_t r;
    r.le = le; r.la = 4'(la); r.ld = ld; r.st = st; r.len = 5'(len); r.rdy = rdy;
    r.e_instr = ei; r.e_valid = ev; r.e_pc = 4'(ep); r.e_busy = eb; r.e_done = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] ei, input logic ev,
                            input logic [3:0] ep, input logic eb, input logic ed);
    check($sformatf("%s.instruction", tag), 32'(instruction), 32'(ei));
    check($sformatf("%s.instr_valid", tag), 32'(instr_valid), 32'(ev));
    check($sformatf("%s.pc", tag),          32'(pc),          32'(ep));
    check($sformatf("%s.busy", tag),        32'(busy),        32'(eb));
    check($sformatf("%s.done", tag),        32'(done),        32'(ed));
  endtask

  task automatic drive(input logic le, input int la, input logic [15:0] ld,
                       input logic st, input int len, input logic rdy);
    load_en     = le;
    load_addr   = 4'(la);
    load_data   = ld;
    start       = st;
    prog_len    = 5'(len);
    issue_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] a0, a1, a2, a3, b0, b1, s0, s1, s2, s3;

  initial begin
    a0 = mk(OP_ADD, 1, 2, 3, 0);   // ADD r1,r2,r3 = 16'h0A60
    a1 = mk(OP_ADD, 4, 5, 6, 0);
    a2 = mk(OP_MUL, 7, 2, 5, 0);
    a3 = mk(OP_ADD, 0, 3, 6, 0);
    b0 = mk(OP_ADD, 1, 2, 3, 0);
    b1 = mk(OP_MUL, 4, 1, 2, 0);   // reads r1 written by b0
    s0 = mk(OP_ADD, 1, 2, 3, 0);
    s1 = mk(OP_ADD, 4, 5, 6, 0);
    s2 = mk(OP_ADD, 5, 2, 3, 0);
    s3 = mk(OP_MUL, 6, 5, 1, 0);   // reads r5 written by s2

    // Independent program: four back-to-back issues, done two cycles after last
    tbl.push_back(row(1, 0, a0, 0, 0, 1, NOP, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, a1, 0, 0, 1, NOP, 0, 0, 0, 0));
    tbl.push_back(row(1, 2, a2, 0, 0, 1, NOP, 0, 0, 0, 0));
    tbl.push_back(row(1, 3, a3, 0, 0, 1, NOP, 0, 0, 0, 0));
    tbl.push_back(row(0, 0, 0,  1, 4, 1, NOP, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, a0,  1, 1, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, a1,  1, 2, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, a2,  1, 3, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, a3,  1, 4, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 4, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 0, 0, 0));
    // RAW hazard: one bubble, pc holds at 1; second load shares the start cycle
    tbl.push_back(row(1, 0, b0, 0, 0, 1, NOP, 0, 0, 0, 0));
    tbl.push_back(row(1, 1, b1, 1, 2, 1, NOP, 0, 0, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, b0,  1, 1, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 1, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, b1,  1, 2, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 2, 1, 0));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 0, 0, 1));
    tbl.push_back(row(0, 0, 0,  0, 0, 1, NOP, 0, 0, 0, 0));

    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    #1 reset_n = 1'b0;
    #1 expect_out("reset", NOP, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].le, int'(tbl[i].la), tbl[i].ld, tbl[i].st, int'(tbl[i].len), tbl[i].rdy);
      step();
      expect_out($sformatf("row%0d", i), tbl[i].e_instr, tbl[i].e_valid,
                 tbl[i].e_pc, tbl[i].e_busy, tbl[i].e_done);
    end

    // Back-pressure: 3-cycle stall, then a stall overlapping a hazard window
    drive(1, 0, s0, 0, 0, 1); step();
    drive(1, 1, s1, 0, 0, 1); step();
    drive(1, 2, s2, 0, 0, 1); step();
    drive(1, 3, s3, 0, 0, 1); step();
    drive(0, 0, 0, 1, 4, 1);  step(); expect_out("stall.start", NOP, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);  step(); expect_out("stall.s0", s0, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(); expect_out($sformatf("stall.hold%0d", k), s0, 1, 1, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 1);  step(); expect_out("stall.s1", s1, 1, 2, 1, 0);
    step();                           expect_out("stall.s2", s2, 1, 3, 1, 0);
    drive(0, 0, 0, 0, 0, 0);  step(); expect_out("stall.bubble", NOP, 0, 3, 1, 0);
    step();                           expect_out("stall.gaphold", NOP, 0, 3, 1, 0);
    drive(0, 0, 0, 0, 0, 1);  step(); expect_out("stall.s3", s3, 1, 4, 1, 0);
    step();                           expect_out("stall.drain", NOP, 0, 4, 1, 0);
    step();                           expect_out("stall.done", NOP, 0, 0, 0, 1);

    // Zero-length program: done on the next cycle, never busy
    drive(0, 0, 0, 1, 0, 1);  step(); expect_out("len0.done", NOP, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);  step(); expect_out("len0.after", NOP, 0, 0, 0, 0);

    // Full-depth program with a stray start and load during RUN
    for (int i = 0; i < 16; i++) begin
      drive(1, i, fw(i), 0, 0, 1); step();
    end
    drive(0, 0, 0, 1, 16, 1); step(); expect_out("full.start", NOP, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) drive(1, 5, 16'hFFFF, 1, 1, 1);
      else        drive(0, 0, 0, 0, 0, 1);
      step();
      expect_out($sformatf("full.w%0d", k), fw(k), 1, 4'((k + 1) % 16), 1, 0);
    end
    drive(0, 0, 0, 0, 0, 1);
    step(); expect_out("full.drain", NOP, 0, 0, 1, 0);
    step(); expect_out("full.done", NOP, 0, 0, 0, 1);
    step(); expect_out("full.idle", NOP, 0, 0, 0, 0);

    // Asynchronous reset at pc=2 aborts without a done pulse
    drive(0, 0, 0, 1, 16, 1); step(); expect_out("rst.start", NOP, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);  step(); expect_out("rst.w0", fw(0), 1, 1, 1, 0);
    step();                           expect_out("rst.w1", fw(1), 1, 2, 1, 0);
    reset_n = 1'b0;
    #1 expect_out("rst.async", NOP, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); expect_out($sformatf("rst.quiet%0d", k), NOP, 0, 0, 0, 0);
    end

    // Restart with prog_len above DEPTH: clamped to 16 issues from pc=0
    drive(0, 0, 0, 1, 20, 1); step(); expect_out("clamp.start", NOP, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      step();
      expect_out($sformatf("clamp.w%0d", k), fw(k), 1, 4'((k + 1) % 16), 1, 0);
    end
    step(); expect_out("clamp.drain", NOP, 0, 0, 1, 0);
    step(); expect_out("clamp.done", NOP, 0, 0, 0, 1);
    step(); expect_out("clamp.idle", NOP, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
